config_sequencer: RTL

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

---
 rtl/config_sequencer_pkg.sv | 45 ++++
 rtl/config_fifo.sv | 60 ++++++
 rtl/config_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/config_sequencer_pkg.sv
// Shared configuration-bus definitions: element plane codes, idle address,
// the buffered word layout and the sequencer state encoding. Tile modules
// import the same plane constants so addresses decode consistently.
package config_sequencer_pkg;

  localparam int unsigned CFG_ADDR_W   = 32;
  localparam int unsigned CFG_DATA_W   = 32;
  localparam int unsigned WORD_COUNT_W = 16;
  localparam int unsigned HOLD_W       = 4;

  // Element plane codes carried in address bits [31:16].
  localparam logic [15:0] PLANE_SB  = 16'd7;
  localparam logic [15:0] PLANE_CB0 = 16'd6;
  localparam logic [15:0] PLANE_CB1 = 16'd5;
  localparam logic [15:0] PLANE_CLB = 16'd4;

  // Plane 16'hFFFF matches no tile element, so this address is harmless.
  localparam logic [CFG_ADDR_W-1:0] IDLE_ADDR_DEFAULT = 32'hFFFF_FFFF;

  // One buffered configuration word.
  typedef struct packed {
    logic                  last;
    logic [CFG_ADDR_W-1:0] addr;
    logic [CFG_DATA_W-1:0] data;
  } cfg_word_t;

  localparam int unsigned CFG_WORD_W = $bits(cfg_word_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Address field helpers shared with tile decoders.
  function automatic logic [15:0] cfg_plane(input logic [CFG_ADDR_W-1:0] addr);
    return addr[31:16];
  endfunction

  function automatic logic [15:0] cfg_tile(input logic [CFG_ADDR_W-1:0] addr);
    return addr[15:0];
  endfunction

endpackage

// File: rtl/config_fifo.sv
// Show-ahead FIFO buffering configuration words ahead of the bus sequencer.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (empties the FIFO)
//   push_i, wdata_i  write request and word; ignored while full
//   pop_i            advance head; ignored while empty
//   rdata_o          current head word (valid when !empty_o)
//   full_o, empty_o  occupancy flags, derived from registered pointers
module config_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match.
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: contents are only read behind a valid pointer.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/config_sequencer.sv
// Configuration bitstream sequencer: buffers incoming words and broadcasts
// each one on the shared configuration bus for HOLD_CYCLES cycles, followed
// by one idle cycle, until the word flagged last has been written.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   cfg_valid/cfg_ready      upstream handshake
//   cfg_addr/cfg_data/cfg_last  upstream word ({plane, tile_id}, payload, end flag)
//   restart                  pulse: leave DONE and clear word_count
//   config_addr/config_data  registered broadcast bus
//   busy                     words buffered or a write in progress
//   done                     registered; last word written, held until restart
//   word_count               registered, saturating count of words driven
module config_sequencer
  import config_sequencer_pkg::*;
#(
  parameter int unsigned            FIFO_DEPTH      = 4,
  parameter int unsigned            HOLD_CYCLES     = 1,
  parameter logic [CFG_ADDR_W-1:0]  IDLE_ADDR       = IDLE_ADDR_DEFAULT,
  // word_count value loaded by reset; 0 in normal use.
  parameter logic [WORD_COUNT_W-1:0] WORD_COUNT_INIT = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CFG_ADDR_W-1:0]   cfg_addr,
  input  logic [CFG_DATA_W-1:0]   cfg_data,
  input  logic                    cfg_last,
  input  logic                    restart,
  output logic [CFG_ADDR_W-1:0]   config_addr,
  output logic [CFG_DATA_W-1:0]   config_data,
  output logic                    busy,
  output logic                    done,
  output logic [WORD_COUNT_W-1:0] word_count
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  seq_state_e              state_q, state_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    last_q, last_d;
  logic [CFG_ADDR_W-1:0]   addr_q, addr_d;
  logic [CFG_DATA_W-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic [WORD_COUNT_W-1:0] wcnt_q, wcnt_d;
  logic                    alive_q;

  cfg_word_t fifo_wdata, fifo_head;
  logic      fifo_full, fifo_empty;
  logic      push_c, pop_c, cnt_inc_c;

  // Held low during reset, rises on the first edge after release.
  assign cfg_ready  = alive_q && !fifo_full;
  assign push_c     = cfg_valid && cfg_ready;
  assign fifo_wdata = {cfg_last, cfg_addr, cfg_data};

  config_fifo #(
    .WIDTH (CFG_WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push_c),
    .wdata_i (fifo_wdata),
    .pop_i   (pop_c),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Next-state, bus and status logic; bus defaults to idle every cycle.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    last_d    = last_q;
    addr_d    = IDLE_ADDR;
    data_d    = '0;
    done_d    = 1'b0;
    pop_c     = 1'b0;
    cnt_inc_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          cnt_inc_c = 1'b1;
          state_d   = ST_DRIVE;
          hold_d    = HOLD_LAST;
          last_d    = fifo_head.last;
          addr_d    = fifo_head.addr;
          data_d    = fifo_head.data;
        end
      end
      ST_DRIVE: begin
        if (hold_q == '0) begin
          state_d = ST_GAP;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
          addr_d = addr_q;
          data_d = data_q;
        end
      end
      ST_GAP: begin
        if (last_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (!fifo_empty) begin
          pop_c     = 1'b1;
          cnt_inc_c = 1'b1;
          state_d   = ST_DRIVE;
          hold_d    = HOLD_LAST;
          last_d    = fifo_head.last;
          addr_d    = fifo_head.addr;
          data_d    = fifo_head.data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        // FIFO keeps filling here; nothing is popped until restart.
        if (restart) begin
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating word counter; restart clears it in any state.
  always_comb begin
    wcnt_d = wcnt_q;
    if (restart) begin
      wcnt_d = WORD_COUNT_W'(cnt_inc_c);
    end else if (cnt_inc_c && (wcnt_q != '1)) begin
      wcnt_d = wcnt_q + WORD_COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      last_q  <= 1'b0;
      addr_q  <= IDLE_ADDR;
      data_q  <= '0;
      done_q  <= 1'b0;
      wcnt_q  <= WORD_COUNT_INIT;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      wcnt_q  <= wcnt_d;
      alive_q <= 1'b1;
    end
  end

  assign config_addr = addr_q;
  assign config_data = data_q;
  assign done        = done_q;
  assign word_count  = wcnt_q;
  assign busy        = !fifo_empty || (state_q == ST_DRIVE) || (state_q == ST_GAP);

endmodule
